layer_mixer: RTL and testbench
==============================

Name: layer_mixer

Overview:
- Parametrised pixel compositor that replaces the fixed two-layer text/graph select and the LED game-state logic at the top level.
- Merges NUM_LAYERS layer pixel streams by fixed priority with per-layer enables, blanking and a background colour.
- Adds a frame-synchronous blink (flash) mode, e.g. for game over.
- Registers the output and delays hsync/vsync/video_on by the same latency so colour and sync stay aligned at the VGA pins.

Parameters:
- NUM_LAYERS, 2, number of input layers; layer NUM_LAYERS-1 has the highest priority.
- RGB_W, 8, colour word width.
- PIPE, 2, output latency in clk cycles; legal range 1..4.
- BLINK_FRAMES, 30, number of frames per blink half-period; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- video_on  in  1  visible-area flag from vga_sync.
- hsync_in  in  1  horizontal sync from vga_sync.
- vsync_in  in  1  vertical sync from vga_sync.
- layer_on  in  NUM_LAYERS  per-layer pixel-present flags.
- layer_rgb  in  NUM_LAYERS*RGB_W  layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
- layer_en  in  NUM_LAYERS  static per-layer enables.
- bg_rgb  in  RGB_W  colour used when no layer is on.
- flash_en  in  1  enables blink mode.
- flash_rgb  in  RGB_W  colour shown during the blink-on phase.
- rgb  out  RGB_W  composited pixel.
- hsync  out  1  hsync_in delayed by PIPE cycles.
- vsync  out  1  vsync_in delayed by PIPE cycles.
- video_on_out  out  1  video_on delayed by PIPE cycles.
- frame_tick  out  1  one-cycle pulse per frame.
- blink_phase  out  1  current blink phase.

Behaviour:
- Reset:
  - Synchronous, active-high. Takes effect on the first clk edge with reset=1.
  - Clears every pipeline stage, so rgb, hsync, vsync and video_on_out are all 0.
  - Clears frame_tick, blink_phase, the frame counter and the vsync edge-detect register to 0.
  - Reset mid-frame or mid-flash: all outputs are 0 on the next edge. Output resumes PIPE cycles after reset is released.
- Selection (stage 1, combinational on the current inputs):
  - Winner = highest index i with layer_on[i] & layer_en[i] = 1.
  - If there is no winner, the pixel is bg_rgb.
  - If video_on = 0, the pixel is 0; blanking overrides everything, including flash.
  - If flash_en & blink_phase & video_on, the pixel is flash_rgb; this overrides all layers and the background.
- Pipeline:
  - Selected pixel, hsync_in, vsync_in and video_on pass through PIPE register stages.
  - An input change at edge T appears at the outputs after edge T+PIPE-1, i.e. a stable output from cycle T+PIPE.
  - No bubbles and no stall; one pixel per clk.
- Frame detect:
  - vsync_prev is registered every cycle.
  - frame_tick = 1 for exactly one cycle after each rising edge of vsync_in (vsync_in=1 & vsync_prev=0).
  - frame_tick is registered, so it appears one cycle after the edge sample. It is not pipelined with rgb.
- Blink:
  - frame_cnt has width clog2(BLINK_FRAMES)+1.
  - While flash_en = 0: frame_cnt = 0 and blink_phase = 0. Each flash sequence therefore starts with a full phase-0 period.
  - While flash_en = 1: each frame edge increments frame_cnt.
  - When frame_cnt = BLINK_FRAMES-1 and a frame edge occurs: frame_cnt wraps to 0 and blink_phase toggles.
  - BLINK_FRAMES = 1: blink_phase toggles on every frame edge.
  - flash_en rising in the same cycle as a frame edge: that edge is not counted.
  - flash_en falling in the same cycle as a frame edge: counter and phase clear; clear wins.
- Widths:
  - No arithmetic on colour words; colours are pure muxing.
  - The counter never overflows because of the wrap compare.

Decomposition:
- Shared package holds:
  - RGB_W default.
  - COLOR_BLACK constant (all zeros).
  - A clog2 function for counter sizing.
- One sub-module, frame_blinker, holds the vsync edge detect, frame_cnt, frame_tick and blink_phase.
- The priority mux and the delay pipeline stay in layer_mixer.

Test Plan:
All tests use NUM_LAYERS=3, RGB_W=8, PIPE=2, BLINK_FRAMES=4.
1. Reset:
   - Drive arbitrary inputs and hold reset=1 for 5 cycles.
   - Required: rgb=0x00, hsync=vsync=video_on_out=0, blink_phase=0, frame_tick=0 throughout.
   - Release reset: valid output appears from the second cycle after release.
2. Priority:
   - video_on=1, layer_en=3'b111, layer_on=3'b011, L0=0x1C, L1=0xE0 → rgb=0xE0 two cycles later.
   - Set layer_en=3'b101 → rgb=0x1C.
   - Set layer_on=3'b000, bg_rgb=0x03 → rgb=0x03.
3. Blanking:
   - video_on=0 with layer_on=3'b111 and flash_en=1, blink_phase=1 → rgb=0x00.
   - video_on_out follows video_on with a 2-cycle delay.
4. Sync alignment:
   - One-cycle hsync_in pulse at cycle 10 and a colour change at cycle 10 → hsync and the new rgb both appear at cycle 12.
5. Flash:
   - flash_en=1, flash_rgb=0xE0, layer pixel 0x1C, then 8 vsync_in rising edges.
   - frame_tick pulses 8 times, one cycle each.
   - blink_phase goes 1 after edge 4 and 0 after edge 8.
   - rgb=0xE0 only while blink_phase=1.
6. Abort:
   - Assert reset (or drop flash_en) while blink_phase=1 → blink_phase=0 and rgb returns to 0x1C.
   - Re-enable flash → 4 frame edges are required before the next toggle.

Source files
------------

// File: rtl/layer_mixer_pkg.sv
// layer_mixer_pkg: shared colour constants and sizing helpers
// for the layer compositor and its frame blinker.
package layer_mixer_pkg;

    localparam int RGB_W_DEF = 8;

    localparam logic [RGB_W_DEF-1:0] COLOR_BLACK = '0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/frame_blinker.sv
// frame_blinker: vsync rising-edge detect, frame tick and
// the frame-counted blink phase used for flash mode.
module frame_blinker
    import layer_mixer_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    input  logic flash_en,
    output logic frame_tick,
    output logic blink_phase
);

    localparam int CW = clog2(BLINK_FRAMES) + 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic          vsync_prev;
    logic          flash_q;
    logic [CW-1:0] frame_cnt;
    logic          frame_edge;

    assign frame_edge = vsync_in & ~vsync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev  <= 1'b0;
            flash_q     <= 1'b0;
            frame_tick  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            flash_q    <= flash_en;
            frame_tick <= frame_edge;
            // flash_q gates out an edge landing in the enable cycle
            if (!flash_en) begin
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_edge && flash_q) begin
                if (frame_cnt == LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// layer_mixer: priority compositor over NUM_LAYERS pixel streams
// with blanking, flash override and sync-aligned output pipeline.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int NUM_LAYERS   = 2,
    parameter int RGB_W        = RGB_W_DEF,
    parameter int PIPE         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        video_on,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic                        flash_en,
    input  logic [RGB_W-1:0]            flash_rgb,
    output logic [RGB_W-1:0]            rgb,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        video_on_out,
    output logic                        frame_tick,
    output logic                        blink_phase
);

    logic [RGB_W-1:0] pix;
    logic [RGB_W-1:0] rgb_q [PIPE];
    logic [2:0]       ctl_q [PIPE];

    frame_blinker #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blinker (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .flash_en   (flash_en),
        .frame_tick (frame_tick),
        .blink_phase(blink_phase)
    );

    // later layers overwrite earlier ones, so the top index wins
    always_comb begin
        pix = bg_rgb;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_on[i] && layer_en[i])
                pix = layer_rgb[i*RGB_W +: RGB_W];
        end
        if (flash_en && blink_phase)
            pix = flash_rgb;
        if (!video_on)
            pix = RGB_W'(COLOR_BLACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                rgb_q[i] <= '0;
                ctl_q[i] <= '0;
            end
        end else begin
            rgb_q[0] <= pix;
            ctl_q[0] <= {video_on, vsync_in, hsync_in};
            for (int i = 1; i < PIPE; i++) begin
                rgb_q[i] <= rgb_q[i-1];
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    assign rgb = rgb_q[PIPE-1];
    assign {video_on_out, vsync, hsync} = ctl_q[PIPE-1];

endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: directed stimulus with a scoreboard queue of
// expected pixels/syncs and blink state, checked by a monitor.
module tb_layer_mixer;

    localparam int NL = 3;
    localparam int W  = 8;
    localparam int P  = 2;
    localparam int BF = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          video_on;
    logic          hsync_in;
    logic          vsync_in;
    logic [NL-1:0] layer_on;
    logic [NL*W-1:0] layer_rgb;
    logic [NL-1:0] layer_en;
    logic [W-1:0]  bg_rgb;
    logic          flash_en;
    logic [W-1:0]  flash_rgb;
    logic [W-1:0]  rgb;
    logic          hsync;
    logic          vsync;
    logic          video_on_out;
    logic          frame_tick;
    logic          blink_phase;

    always #5 clk = ~clk;

    layer_mixer #(
        .NUM_LAYERS  (NL),
        .RGB_W       (W),
        .PIPE        (P),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .layer_on    (layer_on),
        .layer_rgb   (layer_rgb),
        .layer_en    (layer_en),
        .bg_rgb      (bg_rgb),
        .flash_en    (flash_en),
        .flash_rgb   (flash_rgb),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on_out(video_on_out),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    typedef struct {
        int         due;
        logic [W-1:0] rgb;
        logic [2:0] ctl;
    } pix_t;

    typedef struct {
        int   due;
        logic tick;
        logic ph;
    } blk_t;

    pix_t qp[$];
    blk_t qb[$];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_ticks = 0;
    int   m_n = 0;
    logic m_vprev = 1'b0;
    logic m_fq = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic ph();
        return ((m_n / BF) % 2) == 1;
    endfunction

    // Push expectations for the inputs currently driven, then advance.
    task automatic issue(input logic [W-1:0] exp_rgb);
        int   c;
        logic edge_s;
        c = cyc + 1;
        if (reset) begin
            foreach (qp[i]) begin
                if (qp[i].due >= c) begin
                    qp[i].rgb = '0;
                    qp[i].ctl = '0;
                end
            end
            qp.push_back('{c + P - 1, 8'h00, 3'b000});
            m_vprev = 1'b0;
            m_fq    = 1'b0;
            m_n     = 0;
            qb.push_back('{c, 1'b0, 1'b0});
        end else begin
            qp.push_back('{c + P - 1, exp_rgb,
                           {video_on, vsync_in, hsync_in}});
            edge_s  = vsync_in & ~m_vprev;
            m_vprev = vsync_in;
            if (!flash_en) m_n = 0;
            else if (edge_s && m_fq) m_n++;
            m_fq = flash_en;
            qb.push_back('{c, edge_s, ph()});
        end
        @(posedge clk);
        #1;
    endtask

    // Frames of 2 high + 2 low vsync cycles; layer 0 shows 0x1C.
    task automatic frames(input int nf, input int blank_f);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < 4; k++) begin
                vsync_in = (k < 2);
                video_on = (f != blank_f);
                if (!video_on) issue(8'h00);
                else if (flash_en && ph()) issue(8'hE0);
                else issue(8'h1C);
            end
        end
        video_on = 1'b1;
    endtask

    always @(negedge clk) begin
        pix_t e;
        blk_t b;
        while (qp.size() > 0 && qp[0].due <= cyc) begin
            e = qp.pop_front();
            if (e.due == cyc) begin
                n_chk++;
                if (rgb !== e.rgb) begin
                    n_err++;
                    $display("FAIL rgb cyc=%0d got=%h exp=%h",
                             cyc, rgb, e.rgb);
                end
                n_chk++;
                if ({video_on_out, vsync, hsync} !== e.ctl) begin
                    n_err++;
                    $display("FAIL sync cyc=%0d got=%b exp=%b",
                             cyc, {video_on_out, vsync, hsync}, e.ctl);
                end
            end
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            b = qb.pop_front();
            if (b.due == cyc) begin
                n_chk++;
                if (frame_tick !== b.tick) begin
                    n_err++;
                    $display("FAIL frame_tick cyc=%0d got=%b exp=%b",
                             cyc, frame_tick, b.tick);
                end
                n_chk++;
                if (blink_phase !== b.ph) begin
                    n_err++;
                    $display("FAIL blink_phase cyc=%0d got=%b exp=%b",
                             cyc, blink_phase, b.ph);
                end
            end
        end
        if (frame_tick === 1'b1) n_ticks++;
    end

    initial begin
        reset     = 1'b1;
        video_on  = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        layer_on  = 3'b111;
        layer_en  = 3'b111;
        layer_rgb = {8'hFF, 8'hE0, 8'h1C};
        bg_rgb    = 8'h03;
        flash_en  = 1'b1;
        flash_rgb = 8'hE0;

        // reset with arbitrary inputs
        repeat (5) issue(8'h00);
        reset    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        flash_en = 1'b0;

        // priority
        layer_on = 3'b011;
        repeat (3) issue(8'hE0);
        layer_en = 3'b101;
        repeat (3) issue(8'h1C);
        layer_on = 3'b000;
        repeat (3) issue(8'h03);

        // sync alignment with colour change
        layer_on = 3'b010;
        layer_en = 3'b111;
        hsync_in = 1'b1;
        issue(8'hE0);
        hsync_in = 1'b0;
        repeat (3) issue(8'hE0);

        // flash: 8 frames, blanking in frame 5 while phase is 1
        layer_on = 3'b001;
        flash_en = 1'b1;
        n_ticks  = 0;
        issue(8'h1C);
        frames(8, 5);
        issue(8'h1C);
        n_chk++;
        if (n_ticks != 8) begin
            n_err++;
            $display("FAIL tick_count got=%0d exp=8", n_ticks);
        end

        // abort by dropping flash_en while phase is 1
        frames(4, -1);
        flash_en = 1'b0;
        repeat (2) issue(8'h1C);
        flash_en = 1'b1;
        issue(8'h1C);
        frames(4, -1);

        // abort by reset while phase is 1
        reset = 1'b1;
        repeat (2) issue(8'h00);
        reset = 1'b0;
        issue(8'h1C);
        frames(3, -1);

        repeat (4) issue(8'h1C);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
